// File: rtl/tone_decoder.sv
// tone_decoder: measures the period of a square wave and maps it onto
// the buzzer note index, publishing it after CONFIRM stable periods.
module tone_decoder #(
  parameter int unsigned TIMEOUT     = 2000000,
  parameter int unsigned CONFIRM     = 2,
  parameter int unsigned MIN_PERIOD  = 64,
  parameter int unsigned TOL_SHIFT   = 6,
  parameter int unsigned SCALE_SHIFT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wave_in,
  output logic [6:0]  note,
  output logic        note_valid,
  output logic [31:0] period
);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    SEARCH,
    COMMIT
  } state_t;

  localparam logic [4:0] LAST = 5'd21;
  localparam logic [7:0] CONF = 8'(CONFIRM);

  // SCALE_SHIFT divides the timebase for fast-clock self-test builds
  function automatic logic [31:0] half_tbl(input logic [4:0] i);
    logic [31:0] v;
    case (i)
      5'd1:    v = 32'd769231;
      5'd2:    v = 32'd680273;
      5'd3:    v = 32'd606062;
      5'd4:    v = 32'd571429;
      5'd5:    v = 32'd510205;
      5'd6:    v = 32'd454546;
      5'd7:    v = 32'd404859;
      5'd8:    v = 32'd381681;
      5'd9:    v = 32'd340137;
      5'd10:   v = 32'd303031;
      5'd11:   v = 32'd285715;
      5'd12:   v = 32'd255103;
      5'd13:   v = 32'd227273;
      5'd14:   v = 32'd202430;
      5'd15:   v = 32'd191205;
      5'd16:   v = 32'd170358;
      5'd17:   v = 32'd151746;
      5'd18:   v = 32'd143267;
      5'd19:   v = 32'd127714;
      5'd20:   v = 32'd113637;
      5'd21:   v = 32'd101318;
      default: v = 32'd0;
    endcase
    return v >> SCALE_SHIFT;
  endfunction

  state_t      state;
  logic        s1;
  logic        s2;
  logic        prev;
  logic        e;
  logic [31:0] cnt;
  logic [4:0]  idx;
  logic [6:0]  r;
  logic [6:0]  cand;
  logic [7:0]  hits;

  logic [31:0] h;
  logic [31:0] ht;
  logic [31:0] tol;
  logic [31:0] diff;
  logic        hit;
  logic [7:0]  hits_inc;
  logic [6:0]  cand_n;
  logic [7:0]  hits_n;

  assign e = s2 & ~prev;

  always_comb begin
    h        = period >> 1;
    ht       = half_tbl(idx);
    tol      = ht >> TOL_SHIFT;
    diff     = (h >= ht) ? h - ht : ht - h;
    hit      = diff <= tol;
    hits_inc = (hits + 8'd1 >= CONF) ? CONF : hits + 8'd1;
    cand_n   = r;
    hits_n   = 8'd1;
    if (r == cand) begin
      cand_n = cand;
      hits_n = hits_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      prev       <= 1'b0;
      cnt        <= '0;
      period     <= '0;
      state      <= WAIT_FIRST;
      idx        <= '0;
      r          <= '0;
      cand       <= '0;
      hits       <= '0;
      note       <= '0;
      note_valid <= 1'b0;
    end else begin
      s1         <= wave_in;
      s2         <= s1;
      prev       <= s2;
      note_valid <= 1'b0;

      if (e) begin
        cnt <= '0;
      end else if (cnt < TIMEOUT) begin
        cnt <= cnt + 32'd1;
      end

      // the first edge only opens the window; nothing to measure yet
      if (e && state != WAIT_FIRST) begin
        period <= cnt + 32'd1;
      end

      unique case (state)
        WAIT_FIRST: begin
          if (e) state <= MEASURE;
        end
        MEASURE: begin
          if (e) begin
            if (cnt + 32'd1 < MIN_PERIOD) begin
              r     <= '0;
              state <= COMMIT;
            end else begin
              idx   <= 5'd1;
              state <= SEARCH;
            end
          end else if (cnt >= TIMEOUT - 1 && !note_valid) begin
            note       <= '0;
            note_valid <= (note != '0);
            cand       <= '0;
            hits       <= '0;
            state      <= WAIT_FIRST;
          end
        end
        SEARCH: begin
          if (hit) begin
            r     <= {2'b00, idx};
            state <= COMMIT;
          end else if (idx == LAST) begin
            r     <= '0;
            state <= COMMIT;
          end else begin
            idx <= idx + 5'd1;
          end
        end
        COMMIT: begin
          cand <= cand_n;
          hits <= hits_n;
          if (hits_n == CONF && cand_n != note) begin
            note       <= cand_n;
            note_valid <= 1'b1;
          end
          state <= MEASURE;
        end
        default: state <= WAIT_FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_decoder.sv
// tb_tone_decoder: directed vectors on a 1/512 timebase with
// hand-computed note indices, periods and pulse latencies.
module tb_tone_decoder;

  localparam int unsigned TO = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wave_in = 1'b0;
  logic [6:0]  note;
  logic        note_valid;
  logic [31:0] period;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = 0;
  int dbl = 0;
  int edge_cyc = 0;
  int p0 = 0;
  int t_last = 0;
  logic last_nv = 1'b0;

  tone_decoder #(
    .TIMEOUT(TO),
    .SCALE_SHIFT(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wave_in(wave_in),
    .note(note),
    .note_valid(note_valid),
    .period(period)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (note_valid) begin
      pulses++;
      pulse_cyc = cyc;
      if (last_nv) dbl++;
    end
    last_nv = note_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic per(input int hi, input int lo);
    edge_cyc = cyc;
    wave_in = 1'b1;
    repeat (hi) @(negedge clk);
    wave_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic lock(input int hp, input int n);
    repeat (n) per(hp, hp);
  endtask

  task automatic do_reset();
    wave_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_note", 32'(note), 0);
    chk("rst_nv", 32'(note_valid), 0);
    chk("rst_period", period, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // A4: half 443, period 886, index 13
    p0 = pulses;
    per(443, 443);
    per(443, 443);
    chk("a4_hold", 32'(note), 0);
    chk("a4_hold_pulses", 32'(pulses - p0), 0);
    per(443, 443);
    chk("a4_note", 32'(note), 13);
    chk("a4_pulses", 32'(pulses - p0), 1);
    chk("a4_latency", 32'(pulse_cyc - edge_cyc), 17);
    chk("a4_period", period, 886);

    // tolerance: 449 inside A4 band, 469 outside every band
    do_reset();
    lock(449, 3);
    chk("tol_in_note", 32'(note), 13);
    chk("tol_in_period", period, 898);
    do_reset();
    p0 = pulses;
    lock(469, 4);
    chk("tol_out_note", 32'(note), 0);
    chk("tol_out_pulses", 32'(pulses - p0), 0);

    // note change A4 -> C4 (half 745, index 8)
    do_reset();
    lock(443, 3);
    chk("chg_a4", 32'(note), 13);
    p0 = pulses;
    per(745, 745);
    per(745, 745);
    chk("chg_hold", 32'(note), 13);
    per(745, 745);
    chk("chg_c4", 32'(note), 8);
    chk("chg_pulses", 32'(pulses - p0), 1);

    // silence after B5 (half 197, index 21)
    do_reset();
    lock(197, 3);
    chk("sil_lock", 32'(note), 21);
    p0 = pulses;
    t_last = edge_cyc;
    repeat (TO) @(negedge clk);
    chk("sil_note", 32'(note), 0);
    chk("sil_pulses", 32'(pulses - p0), 1);
    chk("sil_latency", 32'(pulse_cyc - t_last), TO + 3);
    chk("sil_state", 32'(dut.state), 0);

    // two 20-cycle glitch periods while locked on C4
    do_reset();
    lock(745, 3);
    chk("gl_lock", 32'(note), 8);
    per(745, 745);
    p0 = pulses;
    per(10, 10);
    per(10, 10);
    per(745, 745);
    chk("gl_zero", 32'(note), 0);
    chk("gl_zero_pulses", 32'(pulses - p0), 1);
    per(745, 745);
    chk("gl_hold", 32'(note), 0);
    per(745, 745);
    chk("gl_relock", 32'(note), 8);
    chk("gl_pulses", 32'(pulses - p0), 2);

    // reset while SEARCH walks toward C4
    wave_in = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs_note", 32'(note), 0);
    chk("rs_nv", 32'(note_valid), 0);
    chk("rs_period", period, 0);
    p0 = pulses;
    repeat (737) @(negedge clk);
    wave_in = 1'b0;
    repeat (100) @(negedge clk);
    rst_n = 1'b1;
    repeat (645) @(negedge clk);
    chk("rs_quiet", 32'(pulses - p0), 0);
    per(745, 745);
    per(745, 745);
    chk("rs_hold", 32'(note), 0);
    per(745, 745);
    chk("rs_relock", 32'(note), 8);
    chk("rs_pulses", 32'(pulses - p0), 1);

    chk("nv_single", 32'(dbl), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
